thread_sched: RTL

Round-robin fetch thread scheduler for the multithreaded front end. Each cycle it selects which hardware thread fetches next and drives that thread id into the fetch stage and the hazard unit. It tracks per-thread blocking caused by I-TLB misses, I-cache misses and hazard squashes, and skips blocked threads until their resolving event arrives.

---
 rtl/thread_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/thread_sched.sv
// thread_sched: round-robin fetch thread scheduler for the multithreaded
// front end. Each cycle it picks the next thread to fetch and skips threads
// blocked on an I-TLB miss, an I-cache miss or (optionally) a squash backoff.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    front end busy; hold the current grant
//   fb_valid/fb_thread       feedback for a fetched instruction, with
//   fb_itlb_miss/            miss and squash qualifiers
//   fb_icache_miss/fb_squash
//   fill_valid/fill_thread   I-cache fill done for a thread
//   tlb_done/tlb_thread      I-TLB miss handled for a thread
//   thread, fetch_valid      registered grant
//   blocked                  per-thread "not READY" flags
//
// Optional feature macro: SCHED_BACKOFF_EN builds the squash BACKOFF state
// and per-thread down-counters. Without it fb_squash is ignored.
module thread_sched #(
  parameter int NTHREADS = 4,
  parameter int TIDW     = $clog2(NTHREADS),
  parameter int BACKOFF  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                fb_valid,
  input  logic [TIDW-1:0]     fb_thread,
  input  logic                fb_itlb_miss,
  input  logic                fb_icache_miss,
  input  logic                fb_squash,
  input  logic                fill_valid,
  input  logic [TIDW-1:0]     fill_thread,
  input  logic                tlb_done,
  input  logic [TIDW-1:0]     tlb_thread,
  output logic [TIDW-1:0]     thread,
  output logic                fetch_valid,
  output logic [NTHREADS-1:0] blocked
);

  if (NTHREADS < 2 || BACKOFF < 1) begin : g_bad_cfg
    $error("thread_sched: NTHREADS must be >= 2 and BACKOFF >= 1");
  end

  typedef enum logic [1:0] {
    S_READY,
    S_WAIT_TLB,
    S_WAIT_MEM,
    S_BACKOFF
  } tstate_e;

  tstate_e st_q [NTHREADS];
  tstate_e st_d [NTHREADS];

`ifdef SCHED_BACKOFF_EN
  localparam int CW = $clog2(BACKOFF + 1);
  logic [CW-1:0] cnt_q [NTHREADS];
  logic [CW-1:0] cnt_d [NTHREADS];
`else
  logic unused_squash;
  assign unused_squash = fb_squash;
`endif

  logic [NTHREADS-1:0] res;
  logic [NTHREADS-1:0] open;
  logic [NTHREADS-1:0] rdy_d;
  logic [TIDW-1:0]     thread_q, thread_d;
  logic [TIDW-1:0]     ptr_q, ptr_d;
  logic [TIDW-1:0]     base, pick, idx;
  logic                fv_q, fv_d;
  logic                found;

  // Per-thread next state. A thread resolving this cycle counts as READY
  // for feedback, so same-cycle feedback re-blocks it.
  always_comb begin
    res     = '0;
    open    = '0;
    rdy_d   = '0;
    blocked = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      st_d[i] = st_q[i];
`ifdef SCHED_BACKOFF_EN
      cnt_d[i] = cnt_q[i];
`endif
      case (st_q[i])
        S_WAIT_TLB:
          res[i] = tlb_done && (tlb_thread == TIDW'(i));
        S_WAIT_MEM:
          res[i] = fill_valid && (fill_thread == TIDW'(i));
`ifdef SCHED_BACKOFF_EN
        S_BACKOFF: begin
          cnt_d[i] = cnt_q[i] - CW'(1);
          res[i]   = (cnt_q[i] == CW'(1));
        end
`endif
        default: res[i] = 1'b0;
      endcase
      if (res[i]) st_d[i] = S_READY;
      open[i] = (st_q[i] == S_READY) || res[i];
      if (open[i] && fb_valid && (fb_thread == TIDW'(i))) begin
        if (fb_itlb_miss) begin
          st_d[i] = S_WAIT_TLB;
        end else if (fb_icache_miss) begin
          st_d[i] = S_WAIT_MEM;
`ifdef SCHED_BACKOFF_EN
        end else if (fb_squash) begin
          st_d[i]  = S_BACKOFF;
          cnt_d[i] = CW'(BACKOFF);
`endif
        end
      end
      rdy_d[i]   = (st_d[i] == S_READY);
      blocked[i] = (st_q[i] != S_READY);
    end
  end

  // Round-robin grant on next-state readiness. A consumed grant moves the
  // pointer; the pointer's own thread is searched last.
  always_comb begin
    base  = (fv_q && !stall) ? thread_q : ptr_q;
    ptr_d = base;
    found = 1'b0;
    pick  = base;
    idx   = base;
    for (int k = 1; k <= NTHREADS; k++) begin
      idx = base + TIDW'(k);
      if (!found && rdy_d[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    if (stall) begin
      thread_d = thread_q;
      fv_d     = fv_q && rdy_d[thread_q];
    end else if (found) begin
      thread_d = pick;
      fv_d     = 1'b1;
    end else begin
      thread_d = thread_q;
      fv_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTHREADS; i++) begin
        st_q[i] <= S_READY;
`ifdef SCHED_BACKOFF_EN
        cnt_q[i] <= '0;
`endif
      end
      thread_q <= '0;
      fv_q     <= 1'b0;
      ptr_q    <= TIDW'(NTHREADS - 1);
    end else begin
      for (int i = 0; i < NTHREADS; i++) begin
        st_q[i] <= st_d[i];
`ifdef SCHED_BACKOFF_EN
        cnt_q[i] <= cnt_d[i];
`endif
      end
      thread_q <= thread_d;
      fv_q     <= fv_d;
      ptr_q    <= ptr_d;
    end
  end

  assign thread      = thread_q;
  assign fetch_valid = fv_q;

endmodule
